// File: rtl/common_dffcam_alloc_ctrl.sv
`timescale 1ns/1ps
// Purpose: lookup-or-allocate sequencer in front of a 1A/1W/1R/1Q DFF CAM; owns all CAM writes.
// Latency: accept cycle T -> resp_valid in cycle T+2 (hit / full), T+3 (allocate / evict).
// Backpressure: one request in flight; req_ready stays low from accept until the response is taken.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready/req_key   lookup-or-insert request (req_ready also gates invalidates)
//   inv_valid/inv_idx          single-entry invalidate, wins over req_valid in IDLE
//   resp_valid/resp_ready      response handshake; resp_hit/resp_full/resp_idx held stable
//   cam_*                      CAM write port (addr/en/we/din/din_valid) and query port
//
// Optional build macro COMMON_DFFCAM_ALLOC_CTRL_EVICT_EN: a miss with no free entry
// overwrites a round-robin victim instead of answering resp_full.
module common_dffcam_alloc_ctrl #(
  parameter int CAM_DEPTH = 8,
  parameter int CAM_WIDTH = 16,
  localparam int IDX_W = $clog2(CAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CAM_WIDTH-1:0] req_key,
  input  logic                 inv_valid,
  input  logic [IDX_W-1:0]     inv_idx,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_hit,
  output logic                 resp_full,
  output logic [IDX_W-1:0]     resp_idx,
  output logic [IDX_W-1:0]     cam_addr,
  output logic                 cam_en,
  output logic                 cam_we,
  output logic [CAM_WIDTH-1:0] cam_din,
  output logic                 cam_din_valid,
  output logic [CAM_WIDTH-1:0] cam_qdata,
  input  logic [IDX_W-1:0]     cam_qaddr,
  input  logic                 cam_qvalid
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_ALLOC  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                r_state;
  logic [CAM_DEPTH-1:0]  r_occ;
  logic [CAM_WIDTH-1:0]  r_key;
  logic [IDX_W-1:0]      r_resp_idx;
  logic                  r_resp_hit;
`ifdef COMMON_DFFCAM_ALLOC_CTRL_EVICT_EN
  logic [IDX_W-1:0]      r_rr;
`else
  logic                  r_resp_full;
`endif

  logic [IDX_W-1:0]      w_free_idx;
  logic                  w_has_free;
  logic                  w_inv_fire;
  logic                  w_alloc_wr;

  // Lowest-numbered free entry: scan downwards so the last hit is the lowest index.
  always_comb begin
    w_free_idx = '0;
    for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
      if (!r_occ[i]) w_free_idx = IDX_W'(i);
    end
  end

  assign w_has_free = ~&r_occ;
  // Reset gates the invalidate write so every output reads 0 while reset is held.
  assign w_inv_fire = (r_state == S_IDLE) && inv_valid && !reset;
  assign w_alloc_wr = (r_state == S_ALLOC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_occ       <= '0;
      r_key       <= '0;
      r_resp_idx  <= '0;
      r_resp_hit  <= 1'b0;
`ifdef COMMON_DFFCAM_ALLOC_CTRL_EVICT_EN
      r_rr        <= '0;
`else
      r_resp_full <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (inv_valid) begin
            r_occ[inv_idx] <= 1'b0;
          end else if (req_valid) begin
            r_key   <= req_key;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_resp_hit <= 1'b0;
`ifndef COMMON_DFFCAM_ALLOC_CTRL_EVICT_EN
          r_resp_full <= 1'b0;
`endif
          if (cam_qvalid) begin
            r_resp_idx <= cam_qaddr;
            r_resp_hit <= 1'b1;
            r_state    <= S_RESP;
          end else if (w_has_free) begin
            r_resp_idx <= w_free_idx;
            r_state    <= S_ALLOC;
          end else begin
`ifdef COMMON_DFFCAM_ALLOC_CTRL_EVICT_EN
            r_resp_idx <= r_rr;
            r_rr       <= r_rr + IDX_W'(1);
            r_state    <= S_ALLOC;
`else
            r_resp_idx  <= '0;
            r_resp_full <= 1'b1;
            r_state     <= S_RESP;
`endif
          end
        end
        S_ALLOC: begin
          r_occ[r_resp_idx] <= 1'b1;
          r_state           <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = (r_state == S_IDLE);
  assign resp_valid    = (r_state == S_RESP);
  assign resp_hit      = r_resp_hit;
  assign resp_idx      = r_resp_idx;
`ifdef COMMON_DFFCAM_ALLOC_CTRL_EVICT_EN
  assign resp_full     = 1'b0;
`else
  assign resp_full     = r_resp_full;
`endif

  // The CAM is only ever written: allocate in ALLOC, clear a valid bit on invalidate.
  assign cam_en        = w_inv_fire | w_alloc_wr;
  assign cam_we        = w_inv_fire | w_alloc_wr;
  assign cam_addr      = w_alloc_wr ? r_resp_idx : (w_inv_fire ? inv_idx : '0);
  assign cam_din       = w_alloc_wr ? r_key : '0;
  assign cam_din_valid = w_alloc_wr;
  assign cam_qdata     = r_key;

endmodule

// File: tb/tb_common_dffcam_alloc_ctrl.sv
`timescale 1ns/1ps
module tb_common_dffcam_alloc_ctrl;
  localparam int DEPTH = 8;
  localparam int W     = 16;
  localparam int IW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0, req_ready;
  logic [W-1:0]  req_key = '0;
  logic          inv_valid = 1'b0;
  logic [IW-1:0] inv_idx = '0;
  logic          resp_valid, resp_ready = 1'b1, resp_hit, resp_full;
  logic [IW-1:0] resp_idx, cam_addr, cam_qaddr;
  logic          cam_en, cam_we, cam_din_valid, cam_qvalid;
  logic [W-1:0]  cam_din, cam_qdata;

  common_dffcam_alloc_ctrl #(.CAM_DEPTH(DEPTH), .CAM_WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .inv_valid(inv_valid), .inv_idx(inv_idx),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_full(resp_full), .resp_idx(resp_idx),
    .cam_addr(cam_addr), .cam_en(cam_en), .cam_we(cam_we), .cam_din(cam_din),
    .cam_din_valid(cam_din_valid), .cam_qdata(cam_qdata),
    .cam_qaddr(cam_qaddr), .cam_qvalid(cam_qvalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CAM instance stand-in: keys plus valid bits, combinational query.
  logic [W-1:0] cm_key [DEPTH];
  logic         cm_v   [DEPTH];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) cm_v[i] <= 1'b0;
    end else if (cam_en && cam_we) begin
      cm_key[cam_addr] <= cam_din;
      cm_v[cam_addr]   <= cam_din_valid;
    end
  end
  always_comb begin
    cam_qvalid = 1'b0;
    cam_qaddr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cm_v[i] && cm_key[i] == cam_qdata) begin
        cam_qvalid = 1'b1;
        cam_qaddr  = IW'(i);
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: table of stored keys with a valid flag each, plus victim pointer.
  typedef struct {
    logic [W-1:0]  key;
    logic          hit;
    logic          full;
    logic [IW-1:0] idx;
    int            lat;
    int            nwr;
    int            acc;
  } exp_t;
  exp_t         q[$];
  logic [W-1:0] m_key [DEPTH];
  bit           m_v   [DEPTH];
  int           m_rr = 0;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
    m_rr = 0;
  endtask

  task automatic push_exp(input logic [W-1:0] key);
    exp_t e;
    int   f = -1;
    e.key = key; e.acc = cyc; e.hit = 1'b0; e.full = 1'b0; e.idx = '0; e.lat = 3; e.nwr = 1;
    for (int i = 0; i < DEPTH; i++) if (m_v[i] && m_key[i] == key) f = i;
    if (f >= 0) begin
      e.hit = 1'b1; e.idx = IW'(f); e.lat = 2; e.nwr = 0;
    end else begin
      for (int i = 0; i < DEPTH; i++) if (!m_v[i] && f < 0) f = i;
`ifdef COMMON_DFFCAM_ALLOC_CTRL_EVICT_EN
      if (f < 0) begin
        f = m_rr;
        m_rr = (m_rr + 1) % DEPTH;
      end
`endif
      if (f < 0) begin
        e.full = 1'b1; e.lat = 2; e.nwr = 0;
      end else begin
        e.idx = IW'(f);
        m_v[f] = 1'b1;
        m_key[f] = key;
      end
    end
    q.push_back(e);
  endtask

  // Monitor: checks CAM writes and responses against the queue head.
  int   wr_cnt = 0;
  logic prev_rv = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_rv = 1'b0;
        wr_cnt  = 0;
      end else begin
        chk("cam_en_vs_we", 32'(cam_en), 32'(cam_we));
        if (cam_en && cam_we) begin
          if (cam_din_valid) begin
            if (q.size() == 0) chk("write_without_req", 32'(q.size()), 32'd1);
            else begin
              chk("alloc_addr", 32'(cam_addr), 32'(q[0].idx));
              chk("alloc_din", 32'(cam_din), 32'(q[0].key));
              wr_cnt++;
            end
          end else begin
            chk("inv_write_cause", 32'(inv_valid), 32'd1);
            chk("inv_addr", 32'(cam_addr), 32'(inv_idx));
            chk("inv_din", 32'(cam_din), 32'd0);
          end
        end
        if (resp_valid) begin
          if (q.size() == 0) chk("resp_without_req", 32'(q.size()), 32'd1);
          else begin
            if (!prev_rv) chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
            chk("resp_hit", 32'(resp_hit), 32'(q[0].hit));
            chk("resp_full", 32'(resp_full), 32'(q[0].full));
            chk("resp_idx", 32'(resp_idx), 32'(q[0].idx));
            chk("req_ready_in_resp", 32'(req_ready), 32'd0);
            chk("cam_qdata", 32'(cam_qdata), 32'(q[0].key));
            if (resp_ready) begin
              chk("cam_write_count", 32'(wr_cnt), 32'(q[0].nwr));
              e = q.pop_front();
              wr_cnt = 0;
            end
          end
        end
        prev_rv = resp_valid;
      end
    end
  end

  // resp_ready source: 0 = always ready, 1 = random, 2 = forced to rdy_val.
  int   rmode = 0;
  logic rdy_val = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #2;
      if (rmode == 2)      resp_ready = rdy_val;
      else if (rmode == 1) resp_ready = ($urandom_range(0, 3) != 0);
      else                 resp_ready = 1'b1;
    end
  end

  task automatic wait_accept(input logic [W-1:0] key);
    int n = 0;
    @(negedge clk);
    while (!(req_ready && !inv_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 32'(n), 32'd0);
    else push_exp(key);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_req(input logic [W-1:0] key);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_key   = key;
    wait_accept(key);
  endtask

  task automatic do_inv(input logic [IW-1:0] idx);
    int n = 0;
    @(posedge clk); #1;
    inv_valid = 1'b1;
    inv_idx   = idx;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("inv_timeout", 32'(n), 32'd0);
    else m_v[idx] = 1'b0;
    @(posedge clk); #1;
    inv_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !req_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'(n), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_hit"}, 32'(resp_hit), 32'd0);
    chk({tag, "_resp_full"}, 32'(resp_full), 32'd0);
    chk({tag, "_resp_idx"}, 32'(resp_idx), 32'd0);
    chk({tag, "_cam_en_we"}, 32'({cam_en, cam_we, cam_din_valid}), 32'd0);
    chk({tag, "_cam_addr"}, 32'(cam_addr), 32'd0);
    chk({tag, "_cam_din"}, 32'(cam_din), 32'd0);
    chk({tag, "_cam_qdata"}, 32'(cam_qdata), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_clear();
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic inserts and a hit.
    do_req(16'h0011);
    do_req(16'h0022);
    do_req(16'h0022);
    drain();

    // Invalidate and request presented together: invalidate first, then allocate idx 0.
    @(posedge clk); #1;
    inv_valid = 1'b1; inv_idx = '0;
    req_valid = 1'b1; req_key = 16'h0033;
    @(negedge clk);
    chk("inv_prio_req_ready", 32'(req_ready), 32'd1);
    m_v[0] = 1'b0;
    @(posedge clk); #1;
    inv_valid = 1'b0;
    wait_accept(16'h0033);
    drain();

    // Response held off for several cycles, then released.
    rmode = 2; rdy_val = 1'b0;
    do_req(16'h0022);
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_resp_seen", 32'(resp_valid), 32'd1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1; rdy_val = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; rdy_val = 1'b0;
    @(negedge clk);
    chk("release_idle_ready", 32'(req_ready), 32'd1);
    chk("release_resp_valid", 32'(resp_valid), 32'd0);
    rmode = 0;
    drain();

    // Reset while the controller is in ALLOC.
    do_req(16'h0044);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk_reset_outputs("alloc_reset");
    q.delete();
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_reset_no_resp", 32'(resp_valid), 32'd0);
    end

    // Fill every entry, then keep missing: full answers or round-robin victims.
    for (int i = 0; i < DEPTH; i++) do_req(16'h0A00 + 16'(i));
    do_req(16'h00FF);
    for (int i = 0; i < 9; i++) do_req(16'h0B00 + 16'(i));
    drain();

    // Randomized mix of requests and invalidates with random backpressure.
    rmode = 1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 4) == 0) do_inv(IW'($urandom_range(0, DEPTH - 1)));
      else if ($urandom_range(0, 1) == 0) do_req(16'h0A00 + 16'($urandom_range(0, 7)));
      else do_req(16'h0100 + 16'($urandom_range(0, 7)));
    end
    rmode = 0;
    drain();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/common_dffcam_alloc_ctrl.md
Name: common_dffcam_alloc_ctrl

Overview:
- Lookup-or-allocate sequencer for a DFF-based 1-address/1-write/1-read/1-query CAM with binary addressing and no bit write enable.
- Accepts key requests from one requester and queries the CAM. On a hit it returns the matching index; on a miss it writes the key into a free entry and returns that index.
- Also serves single-entry invalidate requests.
- Sits between the requester, such as a TLB/tag-table front end, and the CAM instance, and owns all CAM write traffic.

Parameters:
- CAM_DEPTH, 8, number of CAM entries; must be a power of two and at least 2.
- CAM_WIDTH, 16, key width in bits.
- Local parameter IDX_W = $clog2(CAM_DEPTH).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous reset, active-high.
- req_valid  input  1  lookup/allocate request valid.
- req_ready  output  1  controller can accept a request or an invalidate.
- req_key  input  CAM_WIDTH  key to look up or insert.
- inv_valid  input  1  invalidate request valid; shares req_ready.
- inv_idx  input  IDX_W  entry index to invalidate.
- resp_valid  output  1  response valid.
- resp_ready  input  1  requester consumes the response.
- resp_hit  output  1  1 = key was already present.
- resp_full  output  1  1 = miss with no entry available; nothing written.
- resp_idx  output  IDX_W  hit or allocated index.
- cam_addr  output  IDX_W  CAM address port.
- cam_en  output  1  CAM enable.
- cam_we  output  1  CAM write enable.
- cam_din  output  CAM_WIDTH  CAM write data.
- cam_din_valid  output  1  CAM valid bit to write.
- cam_qdata  output  CAM_WIDTH  CAM query key.
- cam_qaddr  input  IDX_W  CAM query match index.
- cam_qvalid  input  1  CAM query match found.

Behaviour:
- Reset values:
  - State IDLE; occupancy bitmap occ = 0; round-robin pointer rr = 0; key_reg = 0.
  - All outputs 0, except req_ready = 1.
  - The CAM's own valid bits must reset to 0, consistent with occ.
- States and transitions:
  - IDLE: req_ready = 1.
    - inv_valid has priority over req_valid when both are high.
    - On inv_valid: same cycle, cam_en = cam_we = 1, cam_addr = inv_idx, cam_din_valid = 0, cam_din = 0. occ[inv_idx] clears at the edge. Stay IDLE. No response is generated. Invalidating an already-free entry is legal and a no-op for occ.
    - On req_valid (without inv_valid): latch key_reg = req_key, go to LOOKUP.
  - LOOKUP: req_ready = 0, cam_qdata = key_reg (cam_qdata holds key_reg in all other states too). The CAM query is combinational.
    - If cam_qvalid: latch resp_idx = cam_qaddr, resp_hit = 1, go to RESP.
    - Else if any occ bit is 0: latch resp_idx = lowest-numbered free index, go to ALLOC.
    - Else (full): behaviour per the optional feature.
  - ALLOC:
    - cam_en = cam_we = 1, cam_addr = resp_idx, cam_din = key_reg, cam_din_valid = 1.
    - occ[resp_idx] sets at the edge. resp_hit = 0. Go to RESP.
  - RESP: resp_valid = 1, with resp_hit/resp_full/resp_idx stable.
    - On resp_ready, go to IDLE; resp_valid drops the next cycle.
    - req_ready stays 0 until IDLE.
- Latency from the accept edge T:
  - Hit: resp_valid at T+2.
  - Allocate: resp_valid at T+3.
  - Full without eviction: resp_valid at T+2.
- Throughput: one request per 3 cycles minimum (hit with resp_ready held high).
- cam_en = 0 in IDLE-without-invalidate, LOOKUP and RESP. The controller never issues a read.
- rr advances modulo CAM_DEPTH, wrapping from CAM_DEPTH-1 to 0, only when a victim is used.
- Asynchronous reset in any state returns to IDLE immediately:
  - Any pending response is discarded.
  - A write in the same cycle as reset is not guaranteed.
- Responses are exactly one per accepted request, in order.

Optional Feature:
- Macro: COMMON_DFFCAM_ALLOC_CTRL_EVICT_EN.
- Defined: on a full miss in LOOKUP, resp_idx = rr, rr increments, go to ALLOC. The entry is overwritten; resp_full = 0, resp_hit = 0. resp_full is tied 0.
- Undefined: on a full miss, go directly to RESP with resp_full = 1, resp_hit = 0, resp_idx = 0. No CAM write; rr is unused and held at 0.

Test Plan:
- Reset, then insert keys 0x0011, 0x0022 (CAM_DEPTH=8): responses hit=0, idx=0 then idx=1. Each resp_valid arrives 3 cycles after accept, with one cam_we pulse carrying din_valid=1.
- Re-request 0x0022: resp_hit=1, resp_idx=1, resp_valid at T+2, no cam_we pulse.
- inv_valid with inv_idx=0 asserted together with req_valid (key 0x0033): invalidate is taken first (cam_we with din_valid=0 at addr 0) and req_ready stays 1. Next cycle the request allocates 0x0033 into idx 0.
- Fill all 8 entries, then request new key 0x00FF.
  - Macro undefined: resp_full=1, no write.
  - Macro defined: victims are idx 0, 1, ... on successive misses, wrapping after idx 7.
- Hold resp_ready=0 for 5 cycles in RESP: resp_valid, resp_idx and resp_hit stay stable and req_ready stays 0. Release: IDLE the next cycle.
- Assert reset during ALLOC: all outputs return to reset values asynchronously, occ=0, req_ready=1, and no response appears after reset deasserts.
